// File: rtl/ras_ckpt_pkg.sv
// Shared defaults and checkpoint layout for the return address stack.
// RAS_TOP_REPAIR_EN adds the top-of-stack value to every checkpoint.
package ras_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int RAS_AW    = 32;
  localparam int RAS_NCKPT = 4;

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = ras_cnt_w(RAS_DEPTH);

  // Layout at the default sizes; ras_ckpt mirrors it for its own parameters.
  typedef struct packed {
    logic [RAS_PTR_W-1:0] tosp;
    logic [RAS_CNT_W-1:0] count;
`ifdef RAS_TOP_REPAIR_EN
    logic [RAS_AW-1:0]    top;
`endif
    logic [RAS_AW-1:0]    fallback;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Dispatch/CDB side of the return address stack: push/pop, checkpoint save and flush.
interface ras_ckpt_if
  import ras_pkg::*;
#(
  parameter int AW = RAS_AW,
  parameter int TW = $clog2(RAS_NCKPT)
);
  logic [AW-1:0] Dis_PcPlusFour;
  logic          Dis_RasJalInst;
  logic          Dis_RasJr31Inst;
  logic          Dis_CkptSave;
  logic [TW-1:0] Dis_CkptTag;
  logic          Cdb_Flush;
  logic [TW-1:0] Cdb_FlushTag;
  logic [AW-1:0] Ras_Addr;
  logic          Ras_Empty;
  logic          Ras_Full;

  modport master (
    output Dis_PcPlusFour, Dis_RasJalInst, Dis_RasJr31Inst,
           Dis_CkptSave, Dis_CkptTag, Cdb_Flush, Cdb_FlushTag,
    input  Ras_Addr, Ras_Empty, Ras_Full
  );

  modport slave (
    input  Dis_PcPlusFour, Dis_RasJalInst, Dis_RasJr31Inst,
           Dis_CkptSave, Dis_CkptTag, Cdb_Flush, Cdb_FlushTag,
    output Ras_Addr, Ras_Empty, Ras_Full
  );
endinterface

// File: rtl/ras_ckpt_file.sv
// Checkpoint slot storage: NCKPT packed snapshots with valid bits, one write and one read port.
module ras_ckpt_file #(
  parameter int NCKPT = 4,
  parameter int W     = 8,
  parameter int TW    = $clog2(NCKPT)
) (
  input  logic          Clk,
  input  logic          Resetb,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [W-1:0]  wr_data,
  input  logic [TW-1:0] rd_tag,
  input  logic          clr_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);

  logic [W-1:0]     slots [NCKPT];
  logic [NCKPT-1:0] valid_q;

  // NOTE: slot contents are qualified by valid_q, so the array needs no reset
  // and maps onto plain registers or RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) slots[wr_tag] <= wr_data;
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[rd_tag] <= 1'b0;
      if (wr_en)  valid_q[wr_tag] <= 1'b1;
    end
  end

  assign rd_data  = slots[rd_tag];
  assign rd_valid = valid_q[rd_tag];

endmodule

// File: rtl/ras_ckpt.sv
// Return address stack with branch checkpoint repair for the dispatch stage.
// Define RAS_TOP_REPAIR_EN to also snapshot and restore the top-of-stack entry.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = RAS_AW,
  parameter int NCKPT = RAS_NCKPT
) (
  input logic        Clk,
  input logic        Resetb,
  ras_ckpt_if.slave  ras
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = ras_cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [PW-1:0] tosp;
    logic [CW-1:0] count;
`ifdef RAS_TOP_REPAIR_EN
    logic [AW-1:0] top;
`endif
    logic [AW-1:0] fallback;
  } ckpt_t;

  localparam int CKW = $bits(ckpt_t);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tosp_q, tosp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] fb_q, fb_d;
  logic          mem_we;
  logic [PW-1:0] mem_wa;
  logic [AW-1:0] mem_wd;
  logic [AW-1:0] top_val;
  ckpt_t         save_d, rest_q;
  logic [CKW-1:0] rd_data;
  logic          slot_vld, restore, push, pop, save;

  // Any flush blocks same-cycle dispatch activity, valid slot or not.
  assign push    = ras.Dis_RasJalInst  && !ras.Cdb_Flush;
  assign pop     = ras.Dis_RasJr31Inst && !ras.Cdb_Flush;
  assign save    = ras.Dis_CkptSave    && !ras.Cdb_Flush;
  assign restore = ras.Cdb_Flush && slot_vld;
  assign top_val = mem[tosp_q];
  assign rest_q  = ckpt_t'(rd_data);

  always_comb begin
    save_d          = '0;
    save_d.tosp     = tosp_q;
    save_d.count    = cnt_q;
`ifdef RAS_TOP_REPAIR_EN
    save_d.top      = top_val;
`endif
    save_d.fallback = fb_q;
  end

  ras_ckpt_file #(.NCKPT(NCKPT), .W(CKW)) u_ckpt_file (
    .Clk      (Clk),
    .Resetb   (Resetb),
    .wr_en    (save),
    .wr_tag   (ras.Dis_CkptTag),
    .wr_data  (save_d),
    .rd_tag   (ras.Cdb_FlushTag),
    .clr_en   (restore),
    .rd_data  (rd_data),
    .rd_valid (slot_vld)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    tosp_d = tosp_q;
    cnt_d  = cnt_q;
    fb_d   = fb_q;
    mem_we = 1'b0;
    mem_wa = tosp_q;
    mem_wd = ras.Dis_PcPlusFour;
    if (restore) begin
      tosp_d = rest_q.tosp;
      cnt_d  = rest_q.count;
      fb_d   = rest_q.fallback;
`ifdef RAS_TOP_REPAIR_EN
      mem_we = 1'b1;
      mem_wa = rest_q.tosp;
      mem_wd = rest_q.top;
`endif
    end else if (push && pop) begin
      mem_we = 1'b1;
    end else if (push) begin
      mem_we = 1'b1;
      mem_wa = tosp_q + 1'b1;
      tosp_d = tosp_q + 1'b1;
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      tosp_d = tosp_q - 1'b1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) fb_d = top_val;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      tosp_q <= PW'(DEPTH - 1);
      cnt_q  <= '0;
      fb_q   <= '0;
    end else begin
      tosp_q <= tosp_d;
      cnt_q  <= cnt_d;
      fb_q   <= fb_d;
    end
  end

  assign ras.Ras_Addr  = (cnt_q != '0) ? top_val : fb_q;
  assign ras.Ras_Empty = (cnt_q == '0);
  assign ras.Ras_Full  = (cnt_q == FULL_CNT);

  // A stale flush tag is tolerated in hardware, so it only warns; a save
  // colliding with push/pop is a dispatch bug.
  always @(posedge Clk) begin
    if (Resetb) begin
      if (!ras.Cdb_Flush)
        assert (!(ras.Dis_CkptSave && (ras.Dis_RasJalInst || ras.Dis_RasJr31Inst)))
          else $error("ras_ckpt: checkpoint save in the same cycle as push/pop");
      if (ras.Cdb_Flush)
        assert (slot_vld)
          else $warning("ras_ckpt: restore from invalid checkpoint slot %0d", ras.Cdb_FlushTag);
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: DEPTH=8 instance for most scenarios, DEPTH=4 for wraparound.
module tb_ras_ckpt;

  logic Clk = 1'b0;
  logic Resetb = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 Clk = ~Clk;

  ras_ckpt_if #(.AW(32), .TW(2)) b8 ();
  ras_ckpt_if #(.AW(32), .TW(2)) b4 ();

  ras_ckpt #(.DEPTH(8), .AW(32), .NCKPT(4)) u_dut8 (.Clk(Clk), .Resetb(Resetb), .ras(b8));
  ras_ckpt #(.DEPTH(4), .AW(32), .NCKPT(4)) u_dut4 (.Clk(Clk), .Resetb(Resetb), .ras(b4));

  task automatic idle_inputs();
    b8.Dis_PcPlusFour = '0; b8.Dis_RasJalInst = 0; b8.Dis_RasJr31Inst = 0;
    b8.Dis_CkptSave = 0; b8.Dis_CkptTag = '0; b8.Cdb_Flush = 0; b8.Cdb_FlushTag = '0;
    b4.Dis_PcPlusFour = '0; b4.Dis_RasJalInst = 0; b4.Dis_RasJr31Inst = 0;
    b4.Dis_CkptSave = 0; b4.Dis_CkptTag = '0; b4.Cdb_Flush = 0; b4.Cdb_FlushTag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Resetb = 1'b0;
    @(negedge Clk);
    Resetb = 1'b1;
  endtask

  // One clock on the DEPTH=8 instance; outputs are settled 1ns after the edge.
  task automatic op8(input logic jal, input logic jr, input logic [31:0] pc,
                     input logic sv, input logic [1:0] tag,
                     input logic fl, input logic [1:0] ftag);
    b8.Dis_RasJalInst = jal; b8.Dis_RasJr31Inst = jr; b8.Dis_PcPlusFour = pc;
    b8.Dis_CkptSave = sv; b8.Dis_CkptTag = tag; b8.Cdb_Flush = fl; b8.Cdb_FlushTag = ftag;
    @(posedge Clk); #1;
    idle_inputs();
  endtask

  task automatic op4(input logic jal, input logic jr, input logic [31:0] pc);
    b4.Dis_RasJalInst = jal; b4.Dis_RasJr31Inst = jr; b4.Dis_PcPlusFour = pc;
    @(posedge Clk); #1;
    idle_inputs();
  endtask

  task automatic chk8(input string name, input logic [31:0] addr, input logic empty, input logic full);
    total++;
    if (b8.Ras_Addr !== addr || b8.Ras_Empty !== empty || b8.Ras_Full !== full) begin
      bad++;
      $display("FAIL %s: got addr=%h empty=%b full=%b want addr=%h empty=%b full=%b",
               name, b8.Ras_Addr, b8.Ras_Empty, b8.Ras_Full, addr, empty, full);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk8("reset_d8", 32'h0, 1'b1, 1'b0);
    total++;
    if (b4.Ras_Addr !== 32'h0 || b4.Ras_Empty !== 1'b1 || b4.Ras_Full !== 1'b0) begin
      bad++;
      $display("FAIL reset_d4: got addr=%h empty=%b full=%b want 0/1/0", b4.Ras_Addr, b4.Ras_Empty, b4.Ras_Full);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("pop_empty", 32'h0, 1'b1, 1'b0);
    op8(1, 0, 32'h111, 0, 0, 0, 0);
    chk8("push_after_empty_pop", 32'h111, 1'b0, 1'b0);
  endtask

  task automatic test_push_pop();
    do_reset();
    op8(1, 0, 32'h100, 0, 0, 0, 0);
    op8(1, 0, 32'h200, 0, 0, 0, 0);
    op8(1, 0, 32'h300, 0, 0, 0, 0);
    chk8("push3_top", 32'h300, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("pop1", 32'h200, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("pop2", 32'h100, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("pop3_fallback", 32'h100, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    logic        exp_empty [4];
    exp_addr  = '{32'h40, 32'h30, 32'h20, 32'h20};
    exp_empty = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 1; i <= 5; i++) op4(1, 0, 32'(i * 16));
    total++;
    if (b4.Ras_Full !== 1'b1 || b4.Ras_Addr !== 32'h50) begin
      bad++;
      $display("FAIL wrap_full: got full=%b addr=%h want full=1 addr=00000050", b4.Ras_Full, b4.Ras_Addr);
    end
    for (int i = 0; i < 4; i++) begin
      op4(0, 1, 32'h0);
      total++;
      if (b4.Ras_Addr !== exp_addr[i] || b4.Ras_Empty !== exp_empty[i] || b4.Ras_Full !== 1'b0) begin
        bad++;
        $display("FAIL wrap_pop%0d: got addr=%h empty=%b full=%b want addr=%h empty=%b full=0",
                 i, b4.Ras_Addr, b4.Ras_Empty, b4.Ras_Full, exp_addr[i], exp_empty[i]);
      end
    end
  endtask

  task automatic test_ckpt_repair();
    logic [31:0] exp;
`ifdef RAS_TOP_REPAIR_EN
    exp = 32'hA0;
`else
    exp = 32'hBB;
`endif
    do_reset();
    op8(1, 0, 32'hA0, 0, 0, 0, 0);
    op8(0, 0, 32'h0, 1, 1, 0, 0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("wrong_path_pop", 32'hA0, 1'b1, 1'b0);
    op8(1, 0, 32'hBB, 0, 0, 0, 0);
    chk8("wrong_path_push", 32'hBB, 1'b0, 1'b0);
    op8(0, 0, 32'h0, 0, 0, 1, 1);
    chk8("restore_tag1", exp, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("restore_count1", exp, 1'b1, 1'b0);
  endtask

  task automatic test_flush_priority();
    do_reset();
    op8(1, 0, 32'h10, 0, 0, 0, 0);
    op8(1, 0, 32'h20, 0, 0, 0, 0);
    op8(0, 0, 32'h0, 1, 0, 0, 0);
    op8(1, 0, 32'h30, 0, 0, 0, 0);
    op8(1, 0, 32'h40, 0, 0, 0, 0);
    chk8("pre_flush", 32'h40, 1'b0, 1'b0);
    op8(1, 0, 32'hCC, 0, 0, 1, 0);
    chk8("flush_drops_push", 32'h20, 1'b0, 1'b0);
    op8(0, 0, 32'h0, 0, 0, 1, 0);
    chk8("flush_invalid_slot", 32'h20, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("flush_pop1", 32'h10, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("flush_pop2", 32'h10, 1'b1, 1'b0);
  endtask

  task automatic test_push_pop_same();
    do_reset();
    op8(1, 0, 32'h40, 0, 0, 0, 0);
    op8(1, 1, 32'h44, 0, 0, 0, 0);
    chk8("pushpop_replace", 32'h44, 1'b0, 1'b0);
    op8(0, 1, 32'h0, 0, 0, 0, 0);
    chk8("pushpop_count_kept", 32'h44, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_restore();
    do_reset();
    op8(1, 0, 32'h55, 0, 0, 0, 0);
    op8(0, 0, 32'h0, 1, 2, 0, 0);
    op8(1, 0, 32'h66, 0, 0, 0, 0);
    b8.Cdb_Flush = 1'b1; b8.Cdb_FlushTag = 2'd2;
    #2 Resetb = 1'b0;
    #1;
    chk8("reset_mid_restore", 32'h0, 1'b1, 1'b0);
    idle_inputs();
    @(negedge Clk);
    Resetb = 1'b1;
    op8(0, 0, 32'h0, 0, 0, 1, 2);
    chk8("slot_cleared_by_reset", 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pop_empty();
    test_push_pop();
    test_wrap();
    test_ckpt_repair();
    test_flush_priority();
    test_push_pop_same();
    test_reset_mid_restore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
